scan_select_sequencer: RTL
==========================

// Module: scan_select_sequencer
// PURPOSE
//  Upstream driver for the 2-to-4 enable decoder. Steps a 2-bit select (a) across
//  the enabled channels of a 4-channel mask, holding each channel for a programmable
//  dwell time. Drives the decoder enable (e) break-before-make: a changes only while e=0.
//  Sits between the control/register block and the decoder (a,e -> y0..y3).
// PARAMETERS
//  DWELL_W   8   width of dwell input and dwell down-counter
// PORTS
//  clk         in   1        single clock; all state updates on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  start       in   1        1-cycle request to begin a frame (ignored unless IDLE)
//  stop        in   1        abort; highest priority
//  ch_mask     in   4        channel enables, bit i = channel i; sampled at frame start
//  dwell       in   DWELL_W  ON cycles per channel; 0 treated as 1; sampled at frame start
//  a           out  2        decoder select (registered)
//  e           out  1        decoder enable (registered)
//  busy        out  1        high in any state except IDLE
//  ch_done     out  1        1-cycle pulse in last ON cycle of each channel
//  frame_done  out  1        1-cycle pulse in BLANK after highest enabled channel
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, a=2'b00, e=0, busy=0, ch_done=0, frame_done=0, cnt=0.
//  FSM: IDLE -> SETUP -> ON -> BLANK -> {SETUP | IDLE}.
//   IDLE : e=0, a holds. start=1 & ch_mask!=0 & stop=0 -> latch mask_q, dwell_q; SETUP.
//          start with ch_mask==0 is ignored (stay IDLE, no pulses).
//   SETUP: one cycle; a <= lowest enabled channel (frame start) or next enabled channel
//          ascending; e=0. Next: ON, e<=1, cnt<=dwell_q-1.
//   ON   : e=1, a stable; cnt decrements; ch_done=1 when cnt==0; then BLANK.
//   BLANK: one cycle; e=0, a unchanged (old channel). If channel was highest set bit of
//          mask_q: frame_done=1 and frame ends (see CONFIGURATION); else SETUP.
//  Latency: start sampled at edge T -> a valid after T+1, e=1 after T+2.
//  Per channel: 1 SETUP + dwell_q ON + 1 BLANK cycles; e and a never change on same edge.
//  stop=1 in any state: next state IDLE, e<=0, a holds, no ch_done/frame_done that cycle.
//  stop and start same cycle: stop wins. start while busy: ignored.
//  Mask/dwell changes mid-frame have no effect until next frame start.
//  Reset mid-frame: immediate return to reset values (e drops asynchronously).
// CONFIGURATION
//  SCAN_SEQ_CONTINUOUS_EN defined: at frame end (BLANK w/ frame_done) re-sample ch_mask and
//   dwell; if ch_mask!=0 go to SETUP with lowest enabled channel (wrap), else IDLE. Runs
//   until stop or mask==0.
//  Not defined: frame end always -> IDLE (single-shot frame).
// STRUCTURE
//  Package scan_seq_pkg: state enum {IDLE,SETUP,ON,BLANK}, NUM_CH=4, SEL_W=2.
//  Sub-module scan_next_ch (combinational): given mask_q and current a, returns next
//   enabled channel above a, first enabled channel, and is_last flag.
// TESTING
//  1 reset: rst_n=0 mid-ON -> a=00, e=0, busy=0 immediately; stays IDLE after release.
//  2 mask=4'b1111, dwell=3, start -> a=0,1,2,3 each with e=1 for 3 cycles, 2 e=0 cycles
//    between; 4 ch_done pulses; frame_done once; busy drops; total 20 cycles.
//  3 mask=4'b1010, dwell=0 -> channels 1 then 3 only, e=1 for 1 cycle each; a never 0/2.
//  4 mask=4'b0000, start -> no activity, busy=0; start while busy -> frame unaffected.
//  5 stop in 2nd ON cycle of ch 2 -> next cycle e=0, a=2, IDLE, no ch_done/frame_done.
//  6 SCAN_SEQ_CONTINUOUS_EN, mask=4'b0011 -> 0,1,0,1..; change mask to 4'b0100 mid-frame
//    -> takes effect after frame_done; without macro: single frame then IDLE.
//  All: checker asserts a stable whenever e=1 and a,e never change on same edge.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan select sequencer.
// Optional continuous-scan behaviour is selected with SCAN_SEQ_CONTINUOUS_EN.
package scan_seq_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;
    localparam logic [1:0] S_BLANK = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SETUP = S_SETUP,
        ON    = S_ON,
        BLANK = S_BLANK
    } state_t;

    function automatic logic [SEL_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        logic found;
        lowest_ch = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mask[i] && !found) begin
                lowest_ch = SEL_W'(i);
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/scan_select_sequencer_next_ch.sv
// Combinational channel walker: next enabled channel above cur, first enabled
// channel, and whether cur is the highest enabled channel.
module scan_next_ch
    import scan_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_ch,
    output logic [SEL_W-1:0]  first_ch,
    output logic              is_last
);

    always_comb begin
        next_ch = cur;
        is_last = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mask[i] && (SEL_W'(i) > cur) && is_last) begin
                next_ch = SEL_W'(i);
                is_last = 1'b0;
            end
        end
    end

    assign first_ch = lowest_ch(mask);

endmodule

// File: rtl/scan_select_sequencer.sv
// Break-before-make select/enable sequencer feeding a 2-to-4 enable decoder.
// Define SCAN_SEQ_CONTINUOUS_EN to rescan frames until stop or an empty mask.
module scan_select_sequencer
    import scan_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   a,
    output logic               e,
    output logic               busy,
    output logic               ch_done,
    output logic               frame_done
);

    state_t              state;
    logic [NUM_CH-1:0]   mask_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [DWELL_W-1:0]  cnt;
    logic [DWELL_W-1:0]  dwell_eff;
    logic [NUM_CH-1:0]   walk_mask;
    logic [SEL_W-1:0]    next_ch;
    logic [SEL_W-1:0]    first_ch;
    logic                is_last;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // In IDLE the walker looks at the live mask so a is loaded on the start edge.
    assign walk_mask = (state == IDLE) ? ch_mask : mask_q;

    scan_next_ch u_next_ch (
        .mask     (walk_mask),
        .cur      (a),
        .next_ch  (next_ch),
        .first_ch (first_ch),
        .is_last  (is_last)
    );

    // a only moves on entry to SETUP and e only toggles around ON, so they never share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            e       <= 1'b0;
            cnt     <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else if (stop) begin
            state <= IDLE;
            e     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        mask_q  <= ch_mask;
                        dwell_q <= dwell_eff;
                        a       <= first_ch;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    e     <= 1'b1;
                    cnt   <= dwell_q - DWELL_W'(1);
                    state <= ON;
                end
                ON: begin
                    if (cnt == '0) begin
                        e     <= 1'b0;
                        state <= BLANK;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                BLANK: begin
                    if (is_last) begin
`ifdef SCAN_SEQ_CONTINUOUS_EN
                        if (ch_mask != '0) begin
                            mask_q  <= ch_mask;
                            dwell_q <= dwell_eff;
                            a       <= lowest_ch(ch_mask);
                            state   <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end else begin
                        a     <= next_ch;
                        state <= SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign ch_done    = (state == ON) && (cnt == '0) && !stop;
    assign frame_done = (state == BLANK) && is_last && !stop;

endmodule
